param_updown_counter: RTL and testbench

- Parametrised synchronous up/down counter; successor to the 4-bit ripple counter.
- Adds the following features:
  - Configurable width and modulus.
  - Direction control, enable, synchronous clear and parallel load.
  - Wrap or saturate mode.
  - Terminal-count and wrap-event outputs.
- Fully synchronous to one clock: no derived clocks.
- Used as a general-purpose event, divider and timeout counter in sequential datapaths.

---
 rtl/param_updown_counter.sv | 76 +++++++
 tb/tb_param_updown_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// param_updown_counter
// General-purpose up/down counter with configurable width and modulus.
// Counts over 0..MAX, with a wrap or saturate choice at either end.
// Also offers synchronous clear and a parallel load that clamps to MAX.
// A one-cycle wrap pulse marks each wrap edge.
// tc and at_limit are decoded combinationally from the registered count.

module param_updown_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             at_limit
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic at_max;
   logic at_zero;
   logic [WIDTH-1:0] load_clamped;

   assign at_max  = (count == MAX);
   assign at_zero = (count == ZERO);

   // A load above MAX would make an unreachable value reachable, so clamp it.
   assign load_clamped = (load_val > MAX) ? MAX : load_val;

   // The limit depends on the direction currently requested, not on en.
   assign at_limit = (up_dn & at_max) | (~up_dn & at_zero);

   // The next enabled edge will perform the limit transition (wrap or hold).
   assign tc = en & at_limit;

   // Count state and wrap pulse: clear beats load beats enabled counting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= ZERO;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            count <= ZERO;
         end else if (load) begin
            count <= load_clamped;
         end else if (en) begin
            if (up_dn) begin
               if (!at_max) begin
                  count <= count + ONE;
               end else if (!sat) begin
                  count <= ZERO;
                  wrap  <= 1'b1;
               end
            end else begin
               if (!at_zero) begin
                  count <= count - ONE;
               end else if (!sat) begin
                  count <= MAX;
                  wrap  <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter
// Scoreboard bench for param_updown_counter.
// Three instances are used: WIDTH=4/MAX=9, WIDTH=8/MAX=255 and WIDTH=1/MAX=1.
// The driver applies one vector per cycle, 1 time unit after the rising edge.
// It then queues the outputs expected while that vector is held.
// The monitor samples 2 time units after the edge.
// It pops the queue and compares against the addressed instance.

module tb_param_updown_counter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       clr4 = 0, load4 = 0, en4 = 0, up4 = 1, sat4 = 0;
   logic [3:0] lv4 = '0;
   logic [3:0] count4;
   logic       tc4, wrap4, al4;

   logic       clr8 = 0, load8 = 0, en8 = 0, up8 = 1, sat8 = 0;
   logic [7:0] lv8 = '0;
   logic [7:0] count8;
   logic       tc8, wrap8, al8;

   logic       clr1 = 0, load1 = 0, en1 = 0, up1 = 1, sat1 = 0;
   logic [0:0] lv1 = '0;
   logic [0:0] count1;
   logic       tc1, wrap1, al1;

   typedef struct {
      int    inst;
      string name;
      int    count;
      int    wrap;
      int    tc;
      int    al;
   } exp_t;

   exp_t q[$];
   int   tests  = 0;
   int   failed = 0;

   param_updown_counter #(.WIDTH(4), .MAX(4'd9)) u4 (
      .clk(clk), .rst(rst), .en(en4), .up_dn(up4), .sat(sat4), .clr(clr4),
      .load(load4), .load_val(lv4), .count(count4), .tc(tc4), .wrap(wrap4),
      .at_limit(al4));

   param_updown_counter #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .en(en8), .up_dn(up8), .sat(sat8), .clr(clr8),
      .load(load8), .load_val(lv8), .count(count8), .tc(tc8), .wrap(wrap8),
      .at_limit(al8));

   param_updown_counter #(.WIDTH(1), .MAX(1'b1)) u1 (
      .clk(clk), .rst(rst), .en(en1), .up_dn(up1), .sat(sat1), .clr(clr1),
      .load(load1), .load_val(lv1), .count(count1), .tc(tc1), .wrap(wrap1),
      .at_limit(al1));

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Drive one vector for the coming edge and queue the outputs expected meanwhile
   task automatic applyStimulus(input int inst, input bit r, input bit c,
                                input bit l, input int lv, input bit e,
                                input bit u, input bit s, input string name,
                                input int ec, input int ew, input int et,
                                input int ea);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r;
      case (inst)
         0: begin clr4 = c; load4 = l; lv4 = 4'(lv); en4 = e; up4 = u; sat4 = s; end
         1: begin clr8 = c; load8 = l; lv8 = 8'(lv); en8 = e; up8 = u; sat8 = s; end
         default: begin clr1 = c; load1 = l; lv1 = 1'(lv); en1 = e; up1 = u; sat1 = s; end
      endcase
      x.inst  = inst;
      x.name  = name;
      x.count = ec;
      x.wrap  = ew;
      x.tc    = et;
      x.al    = ea;
      q.push_back(x);
   endtask

   // Compare one queued expectation against the addressed instance
   task automatic checkOutput(input exp_t x);
      int ac, aw, at, aa;
      case (x.inst)
         0:       begin ac = int'(count4); aw = int'(wrap4); at = int'(tc4); aa = int'(al4); end
         1:       begin ac = int'(count8); aw = int'(wrap8); at = int'(tc8); aa = int'(al8); end
         default: begin ac = int'(count1); aw = int'(wrap1); at = int'(tc1); aa = int'(al1); end
      endcase
      tests++;
      if (ac != x.count || aw != x.wrap || at != x.tc || aa != x.al) begin
         failed++;
         $display("[TB] FAIL %s: got count=%0d wrap=%0d tc=%0d at_limit=%0d, want count=%0d wrap=%0d tc=%0d at_limit=%0d",
                  x.name, ac, aw, at, aa, x.count, x.wrap, x.tc, x.al);
      end
   endtask

   // Monitor: drain every expectation queued for this cycle
   initial begin
      forever begin
         @(posedge clk);
         #2;
         while (q.size() > 0) checkOutput(q.pop_front());
      end
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus sequence
   initial begin
      // Reset state, observed under both directions
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, "reset_up",   0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "reset_down", 0, 0, 0, 1);

      // Up wrap, MAX=9: shown counts 0..9,0,1,2
      for (int i = 0; i <= 12; i++)
         applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, "up_wrap", i % 10,
                       (i == 10) ? 1 : 0, (i == 9) ? 1 : 0, (i == 9) ? 1 : 0);

      // Down wrap: load 2, then 2,1,0,9,8
      applyStimulus(0, 1, 0, 1, 2, 1, 0, 0, "dn_load",  3, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, "dn_wrap2", 2, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, "dn_wrap1", 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, "dn_wrap0", 0, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, "dn_wrap9", 9, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, "dn_wrap8", 8, 0, 0, 0);

      // Down saturate: load 2, then 2,1,0,0,0 with no wrap
      applyStimulus(0, 1, 0, 1, 2, 1, 0, 1, "sat_load", 7, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, "sat_2",    2, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, "sat_1",    1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, "sat_0a",   0, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, "sat_0b",   0, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, "sat_0c",   0, 0, 1, 1);

      // Priority: clear beats load and enable; oversized load clamps to MAX
      applyStimulus(0, 1, 0, 1, 6,  0, 1, 0, "pre_load6",  0, 0, 0, 0);
      applyStimulus(0, 1, 1, 1, 5,  1, 1, 0, "clr_prio",   6, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 14, 1, 1, 0, "load_clamp", 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0,  0, 0, 0, "hold_dn",    9, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0,  0, 1, 0, "hold_up",    9, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0,  0, 0, 0, "hold_dn2",   9, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0,  0, 1, 0, "hold_up2",   9, 0, 0, 1);

      // Async reset mid-count at 7, then count from 0 after release
      applyStimulus(0, 1, 0, 1, 7, 0, 1, 0, "pre_load7", 9, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, "show7",     7, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, "async_rst", 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, "release",   0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, "first_up",  1, 0, 0, 0);

      // Reset kills a pending wrap pulse
      applyStimulus(0, 1, 0, 1, 9, 0, 1, 0, "pre_load9", 2, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, "at9",       9, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, "wrap_kill", 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, "post_kill", 0, 0, 0, 0);

      // Full width 8-bit: 256 enabled edges return to 0 with one wrap pulse
      for (int i = 0; i <= 257; i++)
         applyStimulus(1, 1, 0, 0, 0, 1, 1, 0, "full_width", i % 256,
                       (i == 256) ? 1 : 0, (i == 255) ? 1 : 0, (i == 255) ? 1 : 0);

      // WIDTH=1, MAX=1 toggles; wrap on every 1->0 edge
      for (int i = 0; i <= 5; i++)
         applyStimulus(2, 1, 0, 0, 0, 1, 1, 0, "toggle", i % 2,
                       (i > 0 && (i % 2) == 0) ? 1 : 0, i % 2, i % 2);

      repeat (2) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         failed++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
